// File: rtl/evu_counter_if.sv
// CSR bus between the CSR file (master) and the event-counter unit (slave).
// Single-cycle request, response one cycle later on csr_ack_o/csr_rdata_o.
interface evu_counter_if #(
  parameter int CNT_WIDTH = 64
);
  logic                 csr_req_i;
  logic                 csr_we_i;
  logic [1:0]           csr_addr_i;
  logic [CNT_WIDTH-1:0] csr_wdata_i;
  logic [CNT_WIDTH-1:0] csr_rdata_o;
  logic                 csr_ack_o;

  modport master (
    output csr_req_i, csr_we_i, csr_addr_i, csr_wdata_i,
    input  csr_rdata_o, csr_ack_o
  );

  modport slave (
    input  csr_req_i, csr_we_i, csr_addr_i, csr_wdata_i,
    output csr_rdata_o, csr_ack_o
  );
endinterface

// File: rtl/evu_counter.sv
// Programmable event counter sitting behind the event-select mux.
// Drives the select code, samples the mux output through a one-cycle
// evt_q stage, and counts with threshold compare, wrap detection and a
// level interrupt. Configured through a four-register CSR window.
module evu_counter #(
  parameter int CNT_WIDTH = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        evt_i,
  input  logic        halt_i,
  output logic [3:0]  sel_o,
  output logic        irq_o,
  evu_counter_if.slave csr
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARM    = 2'd1;
  localparam logic [1:0] ST_COUNT  = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_COUNT  = 2'd1;
  localparam logic [1:0] A_THRESH = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic                 en;
  logic                 irq_en;
  logic                 one_shot;
  logic [3:0]           sel;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] thresh;
  logic [CNT_WIDTH-1:0] count_inc;
  logic [CNT_WIDTH-1:0] rd_val;
  logic                 ovf;
  logic                 thr_hit;
  logic                 evt_q;

  logic                 wr_req;
  logic                 rd_req;
  logic                 wr_ctrl;
  logic                 wr_count;
  logic                 wr_thresh;
  logic                 wr_status;
  logic                 inc;
  logic                 wrap_set;
  logic                 thr_set;

  assign wr_req    = csr.csr_req_i & csr.csr_we_i;
  assign rd_req    = csr.csr_req_i & ~csr.csr_we_i;
  assign wr_ctrl   = wr_req & (csr.csr_addr_i == A_CTRL);
  assign wr_count  = wr_req & (csr.csr_addr_i == A_COUNT);
  assign wr_thresh = wr_req & (csr.csr_addr_i == A_THRESH);
  assign wr_status = wr_req & (csr.csr_addr_i == A_STATUS);

  // A captured event still lands after a state change, except when frozen.
  assign inc       = evt_q & (state != ST_HALTED);
  assign count_inc = count + CNT_ONE;
  // A software write to COUNT swallows a coincident increment and its flags.
  assign wrap_set  = inc & ~wr_count & (&count);
  assign thr_set   = inc & ~wr_count & (|thresh) & (count_inc == thresh);

  assign sel_o = sel;
  assign irq_o = irq_en & (ovf | thr_hit);

  // CSR read view of the registers as they stand before this edge.
  always_comb begin
    rd_val = '0;
    case (csr.csr_addr_i)
      A_CTRL:   rd_val[7:0] = {sel, 1'b0, one_shot, irq_en, en};
      A_COUNT:  rd_val      = count;
      A_THRESH: rd_val      = thresh;
      A_STATUS: rd_val[3:0] = {state, thr_hit, ovf};
    endcase
  end

  // Next FSM state; a CTRL write that disables or re-arms overrides the rest.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ARM:   state_nxt = ST_COUNT;
      ST_COUNT: if (one_shot && (wrap_set || thr_set)) state_nxt = ST_HALTED;
      default:  state_nxt = state;
    endcase
    if (wr_ctrl) begin
      if (!csr.csr_wdata_i[0]) begin
        state_nxt = ST_IDLE;
      end else if ((state == ST_IDLE) || (state == ST_HALTED) ||
                   (csr.csr_wdata_i[7:4] != sel)) begin
        state_nxt = ST_ARM;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // CTRL register; sel doubles as the registered mux select.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en       <= 1'b0;
      irq_en   <= 1'b0;
      one_shot <= 1'b0;
      sel      <= 4'd0;
    end else if (wr_ctrl) begin
      en       <= csr.csr_wdata_i[0];
      irq_en   <= csr.csr_wdata_i[1];
      one_shot <= csr.csr_wdata_i[2];
      sel      <= csr.csr_wdata_i[7:4];
    end
  end

  // Event capture: only in COUNT and not halted; ARM blanks the settling mux.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) evt_q <= 1'b0;
    else       evt_q <= (state == ST_COUNT) & evt_i & ~halt_i;
  end

  // Counter: software write beats increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         count <= '0;
    else if (wr_count) count <= csr.csr_wdata_i;
    else if (inc)      count <= count_inc;
  end

  // Threshold register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          thresh <= '0;
    else if (wr_thresh) thresh <= csr.csr_wdata_i;
  end

  // Sticky status flags; a new set wins over a coincident W1C.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf     <= 1'b0;
      thr_hit <= 1'b0;
    end else begin
      ovf     <= (ovf & ~(wr_status & csr.csr_wdata_i[0])) | wrap_set;
      thr_hit <= (thr_hit & ~(wr_status & csr.csr_wdata_i[1])) | thr_set;
    end
  end

  // CSR response one cycle after the request; read data zero otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csr.csr_ack_o   <= 1'b0;
      csr.csr_rdata_o <= '0;
    end else begin
      csr.csr_ack_o   <= csr.csr_req_i;
      csr.csr_rdata_o <= rd_req ? rd_val : '0;
    end
  end

endmodule

// File: tb/tb_evu_counter.sv
// Bench for evu_counter: directed scenarios followed by a randomized run,
// every cycle compared against a behavioural model of the counter unit.
module tb_evu_counter;

  localparam int W = 64;
  localparam int M_IDLE = 0, M_ARM = 1, M_COUNT = 2, M_HALTED = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       evt;
  logic       halt;
  logic [3:0] sel_o;
  logic       irq_o;

  evu_counter_if #(.CNT_WIDTH(W)) csr_if ();

  evu_counter #(.CNT_WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .evt_i  (evt),
    .halt_i (halt),
    .sel_o  (sel_o),
    .irq_o  (irq_o),
    .csr    (csr_if)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  bit         m_en, m_irq_en, m_one;
  logic [3:0] m_sel;
  logic [W-1:0] m_cnt, m_thr;
  bit         m_ovf, m_hit;
  int         m_mode;
  bit         m_pend;   // event seen by the unit, lands one edge later
  bit         m_ack;
  logic [W-1:0] m_rdata;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_en = 0; m_irq_en = 0; m_one = 0; m_sel = 4'd0;
    m_cnt = '0; m_thr = '0; m_ovf = 0; m_hit = 0;
    m_mode = M_IDLE; m_pend = 0; m_ack = 0; m_rdata = '0;
  endtask

  function automatic bit m_irq();
    return m_irq_en && (m_ovf || m_hit);
  endfunction

  // Advance the model by one clock edge using the inputs held this cycle.
  task automatic m_step();
    bit req, we, wrapped, reached, bumped, nxt_pend;
    int a, nxt_mode;
    logic [W-1:0] d, rv, nc;
    req = csr_if.csr_req_i; we = csr_if.csr_we_i;
    a = int'(csr_if.csr_addr_i); d = csr_if.csr_wdata_i;
    case (a)
      0: rv = W'(m_sel) * 64'd16 + W'(m_one) * 64'd4 + W'(m_irq_en) * 64'd2 + W'(m_en);
      1: rv = m_cnt;
      2: rv = m_thr;
      default: rv = W'(m_mode) * 64'd4 + W'(m_hit) * 64'd2 + W'(m_ovf);
    endcase
    bumped = m_pend && (m_mode != M_HALTED);
    wrapped = 0; reached = 0; nc = m_cnt;
    if (req && we && a == 1) nc = d;
    else if (bumped) begin
      nc = m_cnt + 64'd1;
      wrapped = (m_cnt == {W{1'b1}});
      reached = (m_thr != 0) && (nc == m_thr);
    end
    nxt_pend = (m_mode == M_COUNT) && evt && !halt;
    nxt_mode = m_mode;
    if (m_mode == M_ARM) nxt_mode = M_COUNT;
    else if (m_mode == M_COUNT && m_one && (wrapped || reached)) nxt_mode = M_HALTED;
    if (req && we && a == 0) begin
      if (!d[0]) nxt_mode = M_IDLE;
      else if (m_mode == M_IDLE || m_mode == M_HALTED || d[7:4] != m_sel) nxt_mode = M_ARM;
      m_en = d[0]; m_irq_en = d[1]; m_one = d[2]; m_sel = d[7:4];
    end
    if (req && we && a == 2) m_thr = d;
    if (req && we && a == 3) begin
      if (d[0]) m_ovf = 0;
      if (d[1]) m_hit = 0;
    end
    if (wrapped) m_ovf = 1;
    if (reached) m_hit = 1;
    m_cnt = nc; m_mode = nxt_mode; m_pend = nxt_pend;
    m_ack = req;
    m_rdata = (req && !we) ? rv : '0;
  endtask

  // One clock: edge, model update, then compare all outputs.
  task automatic cycle();
    @(posedge clk);
    if (rst) m_reset(); else m_step();
    #1;
    chk("sel_o", W'(sel_o), W'(m_sel));
    chk("irq_o", W'(irq_o), W'(m_irq()));
    chk("csr_ack_o", W'(csr_if.csr_ack_o), W'(m_ack));
    chk("csr_rdata_o", csr_if.csr_rdata_o, m_rdata);
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [W-1:0] d);
    csr_if.csr_req_i = 1'b1; csr_if.csr_we_i = 1'b1;
    csr_if.csr_addr_i = a; csr_if.csr_wdata_i = d;
    cycle();
    csr_if.csr_req_i = 1'b0; csr_if.csr_we_i = 1'b0; csr_if.csr_wdata_i = '0;
  endtask

  task automatic csr_rd(input logic [1:0] a, input logic [W-1:0] exp, input string tag);
    csr_if.csr_req_i = 1'b1; csr_if.csr_we_i = 1'b0;
    csr_if.csr_addr_i = a; csr_if.csr_wdata_i = '0;
    cycle();
    chk(tag, csr_if.csr_rdata_o, exp);
    csr_if.csr_req_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  logic [W-1:0] all_ones;
  logic [W-1:0] wd;

  initial begin
    all_ones = '1;
    rst = 1'b1; evt = 1'b0; halt = 1'b0;
    csr_if.csr_req_i = 1'b0; csr_if.csr_we_i = 1'b0;
    csr_if.csr_addr_i = 2'd0; csr_if.csr_wdata_i = '0;
    m_reset();

    // Reset state
    idle(2);
    rst = 1'b0;
    idle(1);

    // Basic counting, ARM blanking
    csr_wr(2'd0, 64'h21);
    chk("sel_after_ctrl", W'(sel_o), 64'd2);
    evt = 1'b1;
    csr_rd(2'd3, 64'h4, "status_arm");
    evt = 1'b0;
    idle(2);
    evt = 1'b1;
    idle(5);
    evt = 1'b0;
    idle(2);
    csr_rd(2'd1, 64'd5, "count_five");
    csr_rd(2'd3, 64'h8, "status_count");

    // Threshold with one-shot halt and W1C
    csr_wr(2'd0, 64'h0);
    csr_wr(2'd1, 64'h0);
    csr_wr(2'd2, 64'd3);
    csr_wr(2'd0, 64'h27);
    idle(1);
    evt = 1'b1;
    idle(6);
    evt = 1'b0;
    idle(2);
    csr_rd(2'd1, 64'd3, "count_thr_stop");
    chk("irq_thr", W'(irq_o), 64'd1);
    csr_rd(2'd3, 64'hE, "status_halted");
    csr_wr(2'd3, 64'h2);
    chk("irq_cleared", W'(irq_o), 64'd0);

    // Wrap, sticky ovf versus coincident W1C
    csr_wr(2'd2, 64'd0);
    csr_wr(2'd0, 64'h23);
    csr_wr(2'd1, all_ones);
    evt = 1'b1;
    idle(1);
    evt = 1'b0;
    idle(2);
    chk("irq_ovf", W'(irq_o), 64'd1);
    csr_rd(2'd1, 64'd0, "count_wrapped");
    csr_rd(2'd3, 64'h9, "status_ovf");
    csr_wr(2'd1, all_ones);
    evt = 1'b1;
    idle(1);
    evt = 1'b0;
    csr_wr(2'd3, 64'h1);
    idle(1);
    csr_rd(2'd3, 64'h9, "ovf_set_wins");
    csr_rd(2'd1, 64'd0, "count_wrap2");
    csr_wr(2'd0, 64'h21);
    chk("irq_masked", W'(irq_o), 64'd0);
    csr_wr(2'd0, 64'h23);
    chk("irq_unmasked", W'(irq_o), 64'd1);
    csr_wr(2'd3, 64'h1);
    chk("irq_ovf_clear", W'(irq_o), 64'd0);

    // COUNT write coincident with an increment
    csr_wr(2'd1, 64'd0);
    evt = 1'b1;
    idle(3);
    csr_wr(2'd1, 64'd100);
    csr_rd(2'd1, 64'd100, "write_wins");
    csr_rd(2'd1, 64'd101, "inc_after_write");
    csr_rd(2'd1, 64'd102, "inc_after_write2");
    evt = 1'b0;
    idle(2);

    // Select change re-arms; halt freezes capture
    csr_wr(2'd1, 64'd0);
    for (int i = 1; i <= 12; i++) begin
      evt = 1'b1;
      halt = (i >= 8 && i <= 11);
      if (i == 5) begin
        csr_if.csr_req_i = 1'b1; csr_if.csr_we_i = 1'b1;
        csr_if.csr_addr_i = 2'd0; csr_if.csr_wdata_i = 64'h51;
      end else begin
        csr_if.csr_req_i = 1'b0; csr_if.csr_we_i = 1'b0;
        csr_if.csr_wdata_i = '0;
      end
      cycle();
    end
    csr_if.csr_req_i = 1'b0; csr_if.csr_we_i = 1'b0; csr_if.csr_wdata_i = '0;
    evt = 1'b0; halt = 1'b0;
    idle(2);
    csr_rd(2'd1, 64'd7, "count_sel_halt");
    chk("sel_five", W'(sel_o), 64'd5);

    // Asynchronous reset mid-count with a request pending
    csr_wr(2'd0, 64'h53);
    csr_wr(2'd1, all_ones);
    evt = 1'b1;
    idle(2);
    chk("irq_before_rst", W'(irq_o), 64'd1);
    csr_if.csr_req_i = 1'b1; csr_if.csr_we_i = 1'b0; csr_if.csr_addr_i = 2'd1;
    #3;
    rst = 1'b1;
    #1;
    chk("rst_sel", W'(sel_o), 64'd0);
    chk("rst_irq", W'(irq_o), 64'd0);
    chk("rst_ack", W'(csr_if.csr_ack_o), 64'd0);
    chk("rst_rdata", csr_if.csr_rdata_o, 64'd0);
    m_reset();
    csr_if.csr_req_i = 1'b0;
    idle(1);
    rst = 1'b0;
    idle(1);
    chk("no_ack_dropped", W'(csr_if.csr_ack_o), 64'd0);
    evt = 1'b0;
    csr_rd(2'd1, 64'd0, "rst_count");
    csr_rd(2'd0, 64'd0, "rst_ctrl");
    csr_rd(2'd3, 64'd0, "rst_status");

    // Randomized traffic against the model
    csr_wr(2'd0, 64'h23);
    for (int i = 0; i < 600; i++) begin
      evt  = 1'($urandom_range(0, 1));
      halt = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        csr_if.csr_req_i  = 1'b1;
        csr_if.csr_we_i   = 1'($urandom_range(0, 1));
        csr_if.csr_addr_i = 2'($urandom_range(0, 3));
        case (csr_if.csr_addr_i)
          2'd0: wd = W'($urandom_range(2, 3)) * 64'd16 + W'($urandom_range(0, 15)) % 64'd16
                     - W'(0) + (($urandom_range(0, 7) == 0) ? 64'd0 : 64'd1)
                     - W'(0);
          2'd1: begin
            if ($urandom_range(0, 1) == 1) wd = W'($urandom_range(0, 10));
            else wd = all_ones - W'($urandom_range(0, 3));
          end
          2'd2: wd = W'($urandom_range(0, 12));
          default: wd = W'($urandom_range(0, 3));
        endcase
        if (csr_if.csr_addr_i == 2'd0) wd[0] = ($urandom_range(0, 7) != 0);
        csr_if.csr_wdata_i = wd;
      end else begin
        csr_if.csr_req_i = 1'b0; csr_if.csr_we_i = 1'b0; csr_if.csr_wdata_i = '0;
      end
      cycle();
    end
    csr_if.csr_req_i = 1'b0; csr_if.csr_we_i = 1'b0;
    evt = 1'b0; halt = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/evu_counter.md
Name: evu_counter

Overview:
- Programmable event-counter unit on the consuming end of the event-select mux.
- Drives the 4-bit select code to the mux and samples the mux's single-bit event output each cycle.
- Accumulates events in a CNT_WIDTH counter with threshold compare, wrap detection and a level interrupt.
- Exposes a small register-mapped CSR port to the CSR file.

Parameters:
CNT_WIDTH, 64, counter and threshold width (16..64)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
evt_i  in  1  event bit from the event-select mux for the current sel_o
sel_o  out  4  event-select code to the mux (0 selects no event)
halt_i  in  1  freeze counting (debug mode); events ignored while high
csr_req_i  in  1  CSR access request, single-cycle pulse
csr_we_i  in  1  1 = write, 0 = read
csr_addr_i  in  2  0 CTRL, 1 COUNT, 2 THRESH, 3 STATUS
csr_wdata_i  in  CNT_WIDTH  write data
csr_rdata_o  out  CNT_WIDTH  read data, valid while csr_ack_o
csr_ack_o  out  1  access complete, one cycle after csr_req_i
irq_o  out  1  level interrupt

Behaviour:
- Reset values: all registers 0, FSM IDLE, sel_o=0, evt_q=0, csr_ack_o=0, csr_rdata_o=0, irq_o=0.
- CTRL fields:
  - [0] en
  - [1] irq_en
  - [2] one_shot
  - [7:4] sel
  - All other bits read 0.
- sel_o = CTRL.sel, registered.
- STATUS fields:
  - [0] ovf, sticky; writing 1 clears it (W1C)
  - [1] thr_hit, sticky, W1C
  - [3:2] FSM state encoding: IDLE=0, ARM=1, COUNT=2, HALTED=3
  - STATUS state bits are read-only.
- FSM:
  - IDLE: en=0. Go to ARM when CTRL is written with en=1.
  - ARM: exactly one blanking cycle. The mux output is still settling after the select change, so evt_i is discarded and evt_q is forced to 0. Next state is COUNT.
  - COUNT: evt_q <= evt_i & ~halt_i every cycle. Counter increments by 1 on the edge after evt_q=1.
  - HALTED: entered from COUNT when one_shot=1 and ovf or thr_hit sets. Counter is frozen.
  - Any CTRL write with en=0 goes to IDLE from any state.
  - Any CTRL write with en=1 that changes sel, or any CTRL write with en=1 from HALTED, goes to ARM.
- Latency:
  - evt_i high in cycle N (state COUNT) produces COUNT+1 at edge N+2.
  - A read of COUNT issued in cycle N+2 returns the incremented value.
- Wrap: an increment from all-ones gives 0 and sets ovf in the same edge.
- Threshold:
  - THRESH=0 disables the compare.
  - Otherwise thr_hit sets on the edge where the counter becomes equal to THRESH through an increment.
  - A CSR write to COUNT never sets thr_hit, even if the written value equals THRESH.
- irq_o = irq_en & (ovf | thr_hit), from registered state.
- CSR access:
  - Reads and writes take effect at the edge ending the csr_req_i cycle.
  - csr_ack_o is high the following cycle, with csr_rdata_o holding the pre-write register value for reads.
  - csr_rdata_o is 0 when csr_ack_o=0.
  - A new csr_req_i while csr_ack_o=1 is legal (back-to-back accesses).
- Simultaneous events:
  - COUNT write and increment in the same edge: the write wins and the increment is lost.
  - W1C clear of ovf/thr_hit and a new set in the same edge: the set wins.
  - CTRL write to IDLE or ARM in the same edge as an increment: the increment still applies (counter updates, FSM changes).
  - halt_i high: evt_q is forced to 0, and a pending evt_q captured before halt still counts.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); no event is counted on the first edge after reset deassertion.

Test Plan:
- Reset, write CTRL=0x21 (en, sel=2), pulse evt_i for 5 cycles starting 3 cycles later -> sel_o=2, FSM ARM then COUNT, COUNT reads 5, evt_i during ARM not counted.
- THRESH=3, CTRL=0x27 (en, irq_en, one_shot, sel=2), 6 event cycles -> counter stops at 3, thr_hit=1, irq_o=1, STATUS[3:2]=3; W1C 0x2 -> irq_o=0.
- COUNT written to all-ones, one event -> COUNT=0, ovf=1, irq_o follows irq_en; W1C in the same cycle as a second wrap -> ovf stays 1.
- Continuous evt_i, COUNT write of 100 coincident with an increment -> COUNT=100 next read, then +1 per cycle.
- Change sel 2->5 while counting with evt_i held high -> exactly one cycle (ARM) not counted; halt_i high for 4 cycles -> at most 1 extra increment (pipelined evt_q).
- Assert rst_i asynchronously mid-count with csr_req_i pending -> all outputs 0 immediately, csr_ack_o not raised for the dropped request.
